fma_special_pipe: RTL and testbench

//  Parametrised, pipelined special-case/flag stage for the FMA datapath (any IEEE binary format).

---
 rtl/fma_special_pipe.sv | 133 +++++++++++++
 tb/tb_fma_special_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fma_special_pipe.sv
// Special-case and exception-flag stage for an FMA datapath: picks the special or rounded result,
// raises {NV,OF,UF,NX}, and registers it behind a valid/ready handshake with sticky flags and an event counter.
module fma_special_pipe #(
   parameter  int NE    = 5,
   parameter  int NF    = 10,
   parameter  int CNT_W = 8,
   localparam int W     = 1 + NE + NF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     x,
   input  logic [W-1:0]     y,
   input  logic [W-1:0]     z,
   input  logic [W-1:0]     sum,
   input  logic             nonzero_mant,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     result,
   output logic             special,
   output logic [3:0]       flags,
   input  logic             flags_clr,
   output logic [3:0]       fflags,
   output logic [CNT_W-1:0] spec_cnt
);

   typedef struct packed {
      logic nan;
      logic snan;
      logic inf;
      logic zero;
   } FpClass;

   localparam logic [W-1:0] canonNan = {1'b0, {NE{1'b1}}, 1'b1, {(NF-1){1'b0}}};

   function automatic FpClass classify(input logic [W-1:0] v);
      FpClass c;
      logic   expOnes;
      logic   expZero;
      logic   fracZero;
      expOnes  = &v[W-2:NF];
      expZero  = ~|v[W-2:NF];
      fracZero = ~|v[NF-1:0];
      c.nan    = expOnes & ~fracZero;
      c.snan   = c.nan & ~v[NF-1];
      c.inf    = expOnes & fracZero;
      c.zero   = expZero & fracZero;
      return c;
   endfunction

   FpClass         xCls, yCls, zCls;
   logic           prodSign, prodInf, prodZero, accept;
   logic [W-1:0]   resultNew;
   logic           specialNew;
   logic [3:0]     flagsNew;

   assign xCls     = classify(x);
   assign yCls     = classify(y);
   assign zCls     = classify(z);
   assign prodSign = x[W-1] ^ y[W-1];
   assign prodInf  = xCls.inf | yCls.inf;
   assign prodZero = xCls.zero | yCls.zero;

   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;

   // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latch).
   always_comb begin
      resultNew  = sum;
      specialNew = 1'b0;
      flagsNew   = 4'b0000;
      if (xCls.nan | yCls.nan | zCls.nan) begin
         resultNew   = canonNan;
         specialNew  = 1'b1;
         flagsNew[3] = xCls.snan | yCls.snan | zCls.snan;
      end else if ((xCls.inf & yCls.zero) | (xCls.zero & yCls.inf)) begin
         resultNew  = canonNan;
         specialNew = 1'b1;
         flagsNew   = 4'b1000;
      end else if (prodInf & zCls.inf & (prodSign != z[W-1])) begin
         resultNew  = canonNan;
         specialNew = 1'b1;
         flagsNew   = 4'b1000;
      end else if (prodInf) begin
         resultNew  = {prodSign, {NE{1'b1}}, {NF{1'b0}}};
         specialNew = 1'b1;
      end else if (zCls.inf) begin
         resultNew  = z;
         specialNew = 1'b1;
      end else if (prodZero & ~zCls.zero) begin
         resultNew  = z;
         specialNew = 1'b1;
      end else if (prodZero) begin
         // Exact zero sum under round-to-nearest-even is negative only when both terms are.
         resultNew  = {prodSign & z[W-1], {(W-1){1'b0}}};
         specialNew = 1'b1;
      end else if (&sum[W-2:NF]) begin
         resultNew = {sum[W-1], {NE{1'b1}}, {NF{1'b0}}};
         flagsNew  = 4'b0101;
      end else begin
         flagsNew = {2'b00, nonzero_mant & ~|sum[W-2:NF], nonzero_mant};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         special   <= 1'b0;
         flags     <= 4'b0000;
         fflags    <= 4'b0000;
         spec_cnt  <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            result    <= resultNew;
            special   <= specialNew;
            flags     <= flagsNew;
            fflags    <= flags_clr ? flagsNew : (fflags | flagsNew);
            if (specialNew && !(&spec_cnt))
               spec_cnt <= spec_cnt + 1'b1;
         end else begin
            if (out_ready)
               out_valid <= 1'b0;
            if (flags_clr)
               fflags <= 4'b0000;
         end
      end
   end

endmodule

// File: tb/tb_fma_special_pipe.sv
// Directed bench for fma_special_pipe (half precision): expectations are queued when an op is driven
// and compared when the stage presents its output; sticky flags and the counter are tracked alongside.
module tb_fma_special_pipe;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready, nonzero_mant;
   logic [15:0] x, y, z, sum;
   logic        out_valid, out_ready;
   logic [15:0] result;
   logic        special;
   logic [3:0]  flags;
   logic        flags_clr;
   logic [3:0]  fflags;
   logic [7:0]  spec_cnt;

   typedef struct {
      logic [15:0] res;
      logic        spec;
      logic [3:0]  flg;
   } ExpOut;

   ExpOut      sb[$];
   int         nChecks = 0;
   int         nFail   = 0;
   int         expCnt  = 0;
   logic [3:0] fflagsExp = 4'b0000;

   fma_special_pipe #(.NE(5), .NF(10), .CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .z(z), .sum(sum), .nonzero_mant(nonzero_mant),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .special(special), .flags(flags),
      .flags_clr(flags_clr), .fflags(fflags), .spec_cnt(spec_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic presentOp(input logic [15:0] xi, yi, zi, si, input logic nm,
                            input logic [15:0] er, input logic es, input logic [3:0] ef,
                            input logic clr);
      @(negedge clk);
      x = xi; y = yi; z = zi; sum = si; nonzero_mant = nm;
      flags_clr = clr;
      in_valid  = 1'b1;
      sb.push_back('{res: er, spec: es, flg: ef});
      if (es && expCnt != 255) expCnt++;
      fflagsExp = clr ? ef : (fflagsExp | ef);
   endtask

   task automatic sendOp(input logic [15:0] xi, yi, zi, si, input logic nm,
                         input logic [15:0] er, input logic es, input logic [3:0] ef,
                         input logic clr);
      int n = 0;
      presentOp(xi, yi, zi, si, nm, er, es, ef, clr);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("inReadyWait", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      flags_clr = 1'b0;
   endtask

   task automatic checkOut();
      ExpOut e;
      int    n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("outValidWait", {31'd0, out_valid}, 32'd1);
      check("scoreboardNonEmpty", sb.size(), (sb.size() == 0) ? 32'd1 : sb.size());
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("result",  {16'd0, result},   {16'd0, e.res});
         check("special", {31'd0, special},  {31'd0, e.spec});
         check("flags",   {28'd0, flags},    {28'd0, e.flg});
         check("fflags",  {28'd0, fflags},   {28'd0, fflagsExp});
         check("specCnt", {24'd0, spec_cnt}, expCnt);
      end
   endtask

   task automatic clearOnly();
      @(negedge clk);
      in_valid  = 1'b0;
      flags_clr = 1'b1;
      @(posedge clk);
      #1;
      flags_clr = 1'b0;
      fflagsExp = 4'b0000;
      check("fflagsClrAlone", {28'd0, fflags}, 32'h0);
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
      x = '0; y = '0; z = '0; sum = '0; nonzero_mant = 1'b0;
      #3;
      check("rstOutValid", {31'd0, out_valid}, 32'd0);
      check("rstResult",   {16'd0, result},    32'd0);
      check("rstSpecial",  {31'd0, special},   32'd0);
      check("rstFlags",    {28'd0, flags},     32'd0);
      check("rstFflags",   {28'd0, fflags},    32'd0);
      check("rstSpecCnt",  {24'd0, spec_cnt},  32'd0);
      check("rstInReady",  {31'd0, in_ready},  32'd1);
      @(negedge clk);
      reset_n = 1'b1;

      // inf * 0 is invalid
      sendOp(16'h7C00, 16'h0000, 16'h3C00, 16'h5555, 1'b0, 16'h7E00, 1'b1, 4'b1000, 1'b0); checkOut();
      // signed zero results
      sendOp(16'h8000, 16'h3C00, 16'h0000, 16'h5555, 1'b0, 16'h0000, 1'b1, 4'b0000, 1'b0); checkOut();
      sendOp(16'h8000, 16'h3C00, 16'h8000, 16'h5555, 1'b0, 16'h8000, 1'b1, 4'b0000, 1'b0); checkOut();
      // overflow from the rounded path
      sendOp(16'h7BFF, 16'h7BFF, 16'h0000, 16'h7C00, 1'b1, 16'h7C00, 1'b0, 4'b0101, 1'b0); checkOut();
      sendOp(16'h3C00, 16'h3C00, 16'h0000, 16'hFC00, 1'b0, 16'hFC00, 1'b0, 4'b0101, 1'b0); checkOut();
      sendOp(16'h3C00, 16'h3C00, 16'h0000, 16'h7D00, 1'b0, 16'h7C00, 1'b0, 4'b0101, 1'b0); checkOut();
      // NaN inputs: signalling vs quiet
      sendOp(16'h7C01, 16'h3C00, 16'h3C00, 16'h5555, 1'b0, 16'h7E00, 1'b1, 4'b1000, 1'b0); checkOut();
      sendOp(16'h3C00, 16'h3C00, 16'h7E00, 16'h5555, 1'b0, 16'h7E00, 1'b1, 4'b0000, 1'b0); checkOut();
      sendOp(16'h0000, 16'h7C00, 16'hFD00, 16'h5555, 1'b0, 16'h7E00, 1'b1, 4'b1000, 1'b0); checkOut();
      // inf - inf, product inf, addend inf
      sendOp(16'h7C00, 16'h3C00, 16'hFC00, 16'h5555, 1'b0, 16'h7E00, 1'b1, 4'b1000, 1'b0); checkOut();
      sendOp(16'hFC00, 16'h3C00, 16'hFC00, 16'h5555, 1'b0, 16'hFC00, 1'b1, 4'b0000, 1'b0); checkOut();
      sendOp(16'h3C00, 16'h3C00, 16'hFC00, 16'h5555, 1'b0, 16'hFC00, 1'b1, 4'b0000, 1'b0); checkOut();
      // zero product with nonzero addend
      sendOp(16'h0000, 16'h4000, 16'hBC00, 16'h5555, 1'b0, 16'hBC00, 1'b1, 4'b0000, 1'b0); checkOut();
      // normal path: exact, inexact, tiny inexact
      sendOp(16'h3C00, 16'h4000, 16'h3C00, 16'h4200, 1'b0, 16'h4200, 1'b0, 4'b0000, 1'b0); checkOut();
      sendOp(16'h3C01, 16'h3C01, 16'h0000, 16'h3C02, 1'b1, 16'h3C02, 1'b0, 4'b0001, 1'b0); checkOut();
      sendOp(16'h0001, 16'h0001, 16'h0000, 16'h0001, 1'b1, 16'h0001, 1'b0, 4'b0011, 1'b0); checkOut();

      // sticky accumulator sequence
      clearOnly();
      sendOp(16'h7C01, 16'h3C00, 16'h3C00, 16'h5555, 1'b0, 16'h7E00, 1'b1, 4'b1000, 1'b0); checkOut();
      sendOp(16'h3C00, 16'h3C00, 16'h0000, 16'h3C00, 1'b1, 16'h3C00, 1'b0, 4'b0001, 1'b0); checkOut();
      check("fflagsNvNx", {28'd0, fflags}, 32'h9);
      sendOp(16'h7BFF, 16'h7BFF, 16'h0000, 16'h7C00, 1'b1, 16'h7C00, 1'b0, 4'b0101, 1'b1); checkOut();
      check("fflagsClrWithOp", {28'd0, fflags}, 32'h5);
      clearOnly();

      // back-pressure: hold output, block a second op for three cycles
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      sendOp(16'h7C00, 16'h3C00, 16'h3C00, 16'h5555, 1'b0, 16'h7C00, 1'b1, 4'b0000, 1'b0); checkOut();
      presentOp(16'h0000, 16'h4000, 16'hBC00, 16'h5555, 1'b0, 16'hBC00, 1'b1, 4'b0000, 1'b0);
      repeat (3) begin
         check("stallInReady",  {31'd0, in_ready},  32'd0);
         check("stallOutValid", {31'd0, out_valid}, 32'd1);
         check("stallResult",   {16'd0, result},    32'h7C00);
         check("stallFlags",    {28'd0, flags},     32'h0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOut();

      // counter saturation
      for (int i = 0; i < 260; i++) begin
         sendOp(16'h7C00, 16'h0000, 16'h3C00, 16'h5555, 1'b0, 16'h7E00, 1'b1, 4'b1000, 1'b0);
         checkOut();
      end
      check("specCntSaturated", {24'd0, spec_cnt}, 32'hFF);

      // asynchronous reset while holding a valid result
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      sendOp(16'h7C01, 16'h3C00, 16'h3C00, 16'h5555, 1'b0, 16'h7E00, 1'b1, 4'b1000, 1'b0); checkOut();
      #1;
      reset_n = 1'b0;
      #1;
      check("asyncRstOutValid", {31'd0, out_valid}, 32'd0);
      check("asyncRstFflags",   {28'd0, fflags},    32'd0);
      check("asyncRstSpecCnt",  {24'd0, spec_cnt},  32'd0);
      check("asyncRstInReady",  {31'd0, in_ready},  32'd1);
      sb.delete();
      expCnt    = 0;
      fflagsExp = 4'b0000;
      @(negedge clk);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      sendOp(16'h0000, 16'h4000, 16'hBC00, 16'h5555, 1'b0, 16'hBC00, 1'b1, 4'b0000, 1'b0); checkOut();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
